// File: rtl/rv_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_bus_pkg
// Brief    : Shared constants and arbiter state encoding for the result bus.
// Revision : 1.0 - initial release
// ============================================================================
package rv_bus_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage : rv_bus_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Brief    : Combinational round-robin picker, searches upward from ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick8
    import rv_bus_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] w_cand;

    // First set request bit at or above ptr, wrapping modulo 8.
    always_comb begin
        w_cand = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ptr + SEL_W'(k);
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter8
// Brief    : 8-way round-robin bus arbiter with bounded lock and a one-deep
//            valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter8
    import rv_bus_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready,
    output logic                   locked
);

    // Extra bit so lock_cnt + 1 never wraps before the compare.
    localparam logic [4:0] C_MAX_LOCK = 5'(MAX_LOCK);

    arb_state_e       r_state, w_state_nxt;
    logic [SEL_W-1:0] r_own,   w_own_nxt;
    logic [3:0]       r_lock_cnt, w_lock_cnt_nxt;
    logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;

    logic [NREQ-1:0]  w_pick_gnt;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;

    logic             w_load_en;
    logic             w_own_hold;
    logic             w_any;
    logic             w_fire;
    logic [SEL_W-1:0] w_gidx;
    logic [NREQ-1:0]  w_grant;
    logic [3:0]       w_eff_cnt;
    logic [4:0]       w_cnt_inc;
    logic [DATA_W-1:0] w_word;

    rr_pick8 u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The output register can take a new word when empty or being drained.
    assign w_load_en  = !out_valid || out_ready;
    // A held lock only wins while its owner still has a word.
    assign w_own_hold = (r_state == ARB_LOCKED) && req_valid[r_own];
    assign w_gidx     = w_own_hold ? r_own : w_pick_idx;
    assign w_any      = w_own_hold || w_pick_any;
    // rst_n gates the grant so nothing is accepted while reset is held.
    assign w_fire     = rst_n && w_load_en && w_any;
    assign w_grant    = w_own_hold ? (NREQ'(1) << r_own) : w_pick_gnt;
    assign req_ready  = w_fire ? w_grant : '0;

    // A lock that was released by its owner dropping valid restarts the count.
    assign w_eff_cnt  = w_own_hold ? r_lock_cnt : 4'd0;
    assign w_cnt_inc  = {1'b0, w_eff_cnt} + 5'd1;

    // Data path select driven only by the arbitration index.
    assign w_word     = req_data[w_gidx*DATA_W +: DATA_W];

    assign locked     = (r_state == ARB_LOCKED);

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_own      <= '0;
            r_lock_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_own      <= w_own_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    // Next-state: lock entry/exit and pointer advance on accepted beats;
    // everything freezes under backpressure.
    always_comb begin
        w_state_nxt    = r_state;
        w_own_nxt      = r_own;
        w_lock_cnt_nxt = r_lock_cnt;
        w_ptr_nxt      = r_ptr;
        if (w_load_en) begin
            if (w_any) begin
                w_ptr_nxt = w_gidx + SEL_W'(1);
                if (req_lock[w_gidx] && (w_cnt_inc < C_MAX_LOCK)) begin
                    w_state_nxt    = ARB_LOCKED;
                    w_own_nxt      = w_gidx;
                    w_lock_cnt_nxt = w_cnt_inc[3:0];
                end else begin
                    w_state_nxt    = ARB_IDLE;
                    w_lock_cnt_nxt = '0;
                end
            end else begin
                w_state_nxt    = ARB_IDLE;
                w_lock_cnt_nxt = '0;
            end
        end
    end

    // One-deep output register; overwritten in the same edge it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                out_valid <= 1'b1;
                out_data  <= w_word;
                out_sel   <= w_gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : rr_bus_arbiter8
`default_nettype wire

// File: tb/tb_rr_bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter8
// Brief    : Directed self-checking bench for rr_bus_arbiter8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter8;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [7:0]    req_valid;
    logic [7:0]    req_lock;
    logic [8*DW-1:0] req_data;
    logic [7:0]    req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_sel;
    logic          out_ready;
    logic          locked;

    int checks;
    int errors;

    rr_bus_arbiter8 #(.DATA_W(DW), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester k carries word A0000000 + k unless a test overrides it.
    task automatic fill_data();
        for (int k = 0; k < 8; k++) req_data[k*DW +: DW] = 32'hA000_0000 + k;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 8'hFF; req_lock = 8'h00; out_ready = 1'b1;
        fill_data();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b data=%h sel=%0d locked=%b, need 0/0/0/0",
                     out_valid, out_data, out_sel, locked);
        end
        checks++;
        if (req_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_ready: got %h need 00", req_ready);
        end
        @(negedge clk);
        req_valid = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 8'h04;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ready !== 8'h04) begin
            errors++;
            $display("FAIL single_ready: got %h need 04", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 3'd2) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h sel=%0d need 1/deadbeef/2",
                     out_valid, out_data, out_sel);
        end
        @(negedge clk);
        req_valid = 8'h00;
        fill_data();
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: valid=%b need 0", out_valid);
        end
    endtask

    // ptr is 3 after the single beat to requester 2.
    task automatic test_round_robin();
        logic [2:0] exp;
        logic [7:0] exp_rdy;
        for (int i = 0; i < 16; i++) begin
            exp = 3'(3 + i);
            exp_rdy = 8'h01 << exp;
            @(negedge clk);
            req_valid = 8'hFF;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %h need %h", i, req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp || out_data !== (32'hA000_0000 + 32'(exp))) begin
                errors++;
                $display("FAIL rr_out[%0d]: valid=%b sel=%0d data=%h need sel %0d",
                         i, out_valid, out_sel, out_data, exp);
            end
        end
    endtask

    // Output holds requester 2's word, ptr is 3, all requesters valid.
    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 8'h00) begin
            errors++;
            $display("FAIL bp_ready: got %h need 00", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 32'hA000_0002 || req_ready !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h ready=%h need 1/2/a0000002/00",
                         i, out_valid, out_sel, out_data, req_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h08) begin
            errors++;
            $display("FAIL bp_resume_ready: got %h need 08", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_sel !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume_out: sel=%0d valid=%b need 3/1", out_sel, out_valid);
        end
        @(negedge clk);
        req_valid = 8'h00;
        @(posedge clk); #1;
    endtask

    // ptr is 4; one beat to requester 0 moves it to 1 so requester 3 wins first.
    task automatic test_lock_bound();
        logic [2:0] exp_sel [5];
        logic       exp_lck [5];
        exp_sel = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
        exp_lck = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        req_valid = 8'h01;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 8'h28;
        req_lock  = 8'h08;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            @(posedge clk); #1;
            checks++;
            if (out_sel !== exp_sel[i] || locked !== exp_lck[i]) begin
                errors++;
                $display("FAIL lock_beat[%0d]: sel=%0d locked=%b need %0d/%b",
                         i + 1, out_sel, locked, exp_sel[i], exp_lck[i]);
            end
        end
        @(negedge clk);
        req_valid = 8'h00;
        req_lock  = 8'h00;
        @(posedge clk); #1;
    endtask

    // ptr is 6 after the beat to requester 5.
    task automatic test_lock_drop();
        @(negedge clk);
        req_valid = 8'h02;
        req_lock  = 8'h02;
        @(posedge clk); #1;
        checks++;
        if (locked !== 1'b1 || out_sel !== 3'd1) begin
            errors++;
            $display("FAIL drop_setup: locked=%b sel=%0d need 1/1", locked, out_sel);
        end
        @(negedge clk);
        req_valid = 8'h40;
        req_lock  = 8'h00;
        #1;
        checks++;
        if (req_ready !== 8'h40) begin
            errors++;
            $display("FAIL drop_ready: got %h need 40", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (locked !== 1'b0 || out_sel !== 3'd6) begin
            errors++;
            $display("FAIL drop_out: locked=%b sel=%0d need 0/6", locked, out_sel);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 8'hFF;
        req_lock  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: locked=%b valid=%b need 1/1", locked, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || locked !== 1'b0 || req_ready !== 8'h00) begin
            errors++;
            $display("FAIL ar_clear: valid=%b locked=%b ready=%h need 0/0/00",
                     out_valid, locked, req_ready);
        end
        @(negedge clk);
        req_lock = 8'h00;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 8'h01) begin
            errors++;
            $display("FAIL ar_first_ready: got %h need 01", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0) begin
            errors++;
            $display("FAIL ar_first_out: valid=%b sel=%0d need 1/0", out_valid, out_sel);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock_bound();
        test_lock_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_rr_bus_arbiter8
`default_nettype wire
